// File: rtl/subservient_sram_arb.sv
// Purpose : round-robin arbiter for two 32-bit Wishbone-style requesters in front of
//           the byte-wide subservient SRAM. Each word access runs as four byte cycles.
// Latency : grant at T, bytes T+1..T+4; write ack T+5, read ack T+6 (DRAIN at T+5).
// Backpressure: a requester holds stb until its ack. The loser of a contention waits
//           at most one transaction. stb is ignored outside IDLE.
//
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_wbN_adr/dat/sel/we/stb    requester N (0 = CPU, 1 = debug/loader) command
//   o_wbN_rdt, o_wbN_ack        requester N read word and one-cycle completion pulse
//   o_sram_waddr/wdata/wen      SRAM byte write port
//   o_sram_raddr/ren            SRAM byte read port (registered read data, 1-cycle)
//   i_sram_rdata                SRAM read data
module subservient_sram_arb #(
    parameter int aw = 10
) (
    input  logic          i_clk,
    input  logic          i_rst_n,

    input  logic [aw-1:0] i_wb0_adr,
    input  logic [31:0]   i_wb0_dat,
    input  logic [3:0]    i_wb0_sel,
    input  logic          i_wb0_we,
    input  logic          i_wb0_stb,
    output logic [31:0]   o_wb0_rdt,
    output logic          o_wb0_ack,

    input  logic [aw-1:0] i_wb1_adr,
    input  logic [31:0]   i_wb1_dat,
    input  logic [3:0]    i_wb1_sel,
    input  logic          i_wb1_we,
    input  logic          i_wb1_stb,
    output logic [31:0]   o_wb1_rdt,
    output logic          o_wb1_ack,

    output logic [aw-1:0] o_sram_waddr,
    output logic [7:0]    o_sram_wdata,
    output logic          o_sram_wen,
    output logic [aw-1:0] o_sram_raddr,
    output logic          o_sram_ren,
    input  logic [7:0]    i_sram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_DRAIN = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          gnt_q,   gnt_d;
    logic          last_q,  last_d;
    logic [1:0]    cnt_q,   cnt_d;
    logic [aw-3:0] wadr_q,  wadr_d;   // word address; byte lanes come from cnt
    logic [31:0]   dat_q,   dat_d;
    logic [3:0]    sel_q,   sel_d;
    logic          we_q,    we_d;
    logic [31:0]   rdt_q,   rdt_d;
    logic          ack0_q,  ack0_d;
    logic          ack1_q,  ack1_d;

    logic          pick;

    // Byte-lane bits of the requester addresses are word-aligned and deliberately unused.
    logic          unused_adr_lsbs;
    assign unused_adr_lsbs = ^{i_wb0_adr[1:0], i_wb1_adr[1:0]};

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        wadr_d  = wadr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        rdt_d   = rdt_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        pick    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Sole requester wins; on contention the port not served last wins.
                if (i_wb0_stb && i_wb1_stb) begin
                    pick = ~last_q;
                end else begin
                    pick = i_wb1_stb;
                end
                if (i_wb0_stb || i_wb1_stb) begin
                    gnt_d   = pick;
                    last_d  = pick;
                    cnt_d   = 2'd0;
                    state_d = S_XFER;
                    if (pick) begin
                        wadr_d = i_wb1_adr[aw-1:2];
                        dat_d  = i_wb1_dat;
                        sel_d  = i_wb1_sel;
                        we_d   = i_wb1_we;
                    end else begin
                        wadr_d = i_wb0_adr[aw-1:2];
                        dat_d  = i_wb0_dat;
                        sel_d  = i_wb0_sel;
                        we_d   = i_wb0_we;
                    end
                end
            end

            S_XFER: begin
                // Read data lags the address by one cycle, so cycle cnt captures byte cnt-1.
                if (!we_q) begin
                    case (cnt_q)
                        2'd1:    rdt_d[7:0]   = i_sram_rdata;
                        2'd2:    rdt_d[15:8]  = i_sram_rdata;
                        2'd3:    rdt_d[23:16] = i_sram_rdata;
                        default: ;
                    endcase
                end
                if (cnt_q == 2'd3) begin
                    // cnt stays at 3 so the SRAM addresses hold their last value.
                    if (we_q) begin
                        state_d = S_ACK;
                        ack0_d  = ~gnt_q;
                        ack1_d  = gnt_q;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end

            S_DRAIN: begin
                rdt_d[31:24] = i_sram_rdata;
                state_d      = S_ACK;
                ack0_d       = ~gnt_q;
                ack1_d       = gnt_q;
            end

            S_ACK: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 2'd0;
            wadr_q  <= '0;
            dat_q   <= 32'd0;
            sel_q   <= 4'd0;
            we_q    <= 1'b0;
            rdt_q   <= 32'd0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            wadr_q  <= wadr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            rdt_q   <= rdt_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
        end
    end

    // SRAM controls decode only registered state, so no stb reaches them combinationally.
    logic xfer;
    assign xfer = (state_q == S_XFER);

    assign o_sram_waddr = {wadr_q, cnt_q};
    assign o_sram_raddr = {wadr_q, cnt_q};
    assign o_sram_wdata = dat_q[{cnt_q, 3'b000} +: 8];
    assign o_sram_wen   = xfer & we_q & sel_q[cnt_q];
    assign o_sram_ren   = xfer & ~we_q;

    assign o_wb0_rdt = rdt_q;
    assign o_wb1_rdt = rdt_q;
    assign o_wb0_ack = ack0_q;
    assign o_wb1_ack = ack1_q;

endmodule

// File: tb/tb_subservient_sram_arb.sv
module tb_subservient_sram_arb;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] wb0_adr, wb1_adr;
    logic [31:0]   wb0_dat, wb1_dat;
    logic [3:0]    wb0_sel, wb1_sel;
    logic          wb0_we,  wb1_we;
    logic          wb0_stb, wb1_stb;
    logic [31:0]   wb0_rdt, wb1_rdt;
    logic          wb0_ack, wb1_ack;
    logic [AW-1:0] sram_waddr, sram_raddr;
    logic [7:0]    sram_wdata, sram_rdata;
    logic          sram_wen, sram_ren;

    always #5 clk = ~clk;

    subservient_sram_arb #(.aw(AW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_wb0_adr    (wb0_adr),
        .i_wb0_dat    (wb0_dat),
        .i_wb0_sel    (wb0_sel),
        .i_wb0_we     (wb0_we),
        .i_wb0_stb    (wb0_stb),
        .o_wb0_rdt    (wb0_rdt),
        .o_wb0_ack    (wb0_ack),
        .i_wb1_adr    (wb1_adr),
        .i_wb1_dat    (wb1_dat),
        .i_wb1_sel    (wb1_sel),
        .i_wb1_we     (wb1_we),
        .i_wb1_stb    (wb1_stb),
        .o_wb1_rdt    (wb1_rdt),
        .o_wb1_ack    (wb1_ack),
        .o_sram_waddr (sram_waddr),
        .o_sram_wdata (sram_wdata),
        .o_sram_wen   (sram_wen),
        .o_sram_raddr (sram_raddr),
        .o_sram_ren   (sram_ren),
        .i_sram_rdata (sram_rdata)
    );

    // Byte SRAM with registered read data, plus a count of write strobes.
    logic [7:0] mem [0:(1<<AW)-1];
    int         wen_cnt = 0;
    always @(posedge clk) begin
        if (sram_wen) begin
            mem[sram_waddr] <= sram_wdata;
            wen_cnt         <= wen_cnt + 1;
        end
        if (sram_ren) sram_rdata <= mem[sram_raddr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int p, input logic we, input logic [AW-1:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
        if (p != 0) begin
            wb1_we = we; wb1_adr = adr; wb1_dat = dat; wb1_sel = sel; wb1_stb = 1'b1;
        end else begin
            wb0_we = we; wb0_adr = adr; wb0_dat = dat; wb0_sel = sel; wb0_stb = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_wen"},   sram_wen,   0);
        chk({pfx, "_ren"},   sram_ren,   0);
        chk({pfx, "_waddr"}, sram_waddr, 0);
        chk({pfx, "_raddr"}, sram_raddr, 0);
        chk({pfx, "_wdata"}, sram_wdata, 0);
        chk({pfx, "_ack0"},  wb0_ack,    0);
        chk({pfx, "_ack1"},  wb1_ack,    0);
        chk({pfx, "_rdt0"},  wb0_rdt,    0);
        chk({pfx, "_rdt1"},  wb1_rdt,    0);
    endtask

    // Counts negedges until port p acks; the other port must stay silent meanwhile.
    task automatic wait_ack(input int p, output int cyc);
        logic done;
        done = 1'b0;
        cyc  = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            chk("other_ack", (p != 0) ? wb0_ack : wb1_ack, 0);
            if ((p != 0) ? wb1_ack : wb0_ack) done = 1'b1;
        end
        chk("ack_seen", done, 1);
    endtask

    // Called at a negedge of an IDLE cycle; returns at the negedge of the next IDLE cycle.
    task automatic do_txn(input int p, input logic we, input logic [AW-1:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel,
                          input int exp_lat, output logic [31:0] rdt);
        int cyc;
        drive(p, we, adr, dat, sel);
        wait_ack(p, cyc);
        chk("txn_latency", cyc, exp_lat);
        rdt = (p != 0) ? wb1_rdt : wb0_rdt;
        if (p != 0) wb1_stb = 1'b0; else wb0_stb = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] w;
        int          cyc;
        int          n_ack;
        int          wen_before;

        rst_n = 1'b1;
        wb0_adr = '0; wb0_dat = '0; wb0_sel = '0; wb0_we = 1'b0; wb0_stb = 1'b0;
        wb1_adr = '0; wb1_dat = '0; wb1_sel = '0; wb1_we = 1'b0; wb1_stb = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Port 0 full write, byte by byte.
        w = 32'hDEADBEEF;
        drive(0, 1'b1, 10'h010, w, 4'hF);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("w1_wen",   sram_wen,   1);
            chk("w1_waddr", sram_waddr, 32'h10 + k);
            chk("w1_wdata", sram_wdata, w[8*k +: 8]);
            chk("w1_ren",   sram_ren,   0);
            chk("w1_ack0",  wb0_ack,    0);
        end
        @(negedge clk);
        chk("w1_ack0_t5", wb0_ack,  1);
        chk("w1_ack1_t5", wb1_ack,  0);
        chk("w1_wen_t5",  sram_wen, 0);
        wb0_stb = 1'b0;
        @(negedge clk);
        chk("w1_ack0_t6", wb0_ack, 0);

        // Port 1 read of the same word.
        drive(1, 1'b0, 10'h010, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("r1_ren",   sram_ren,   1);
            chk("r1_raddr", sram_raddr, 32'h10 + k);
            chk("r1_wen",   sram_wen,   0);
        end
        @(negedge clk);
        chk("r1_drain_ren", sram_ren, 0);
        chk("r1_drain_ack", wb1_ack,  0);
        @(negedge clk);
        chk("r1_ack1", wb1_ack, 1);
        chk("r1_ack0", wb0_ack, 0);
        chk("r1_rdt1", wb1_rdt, 32'hDEADBEEF);
        chk("r1_rdt0", wb0_rdt, 32'hDEADBEEF);
        wb1_stb = 1'b0;
        @(negedge clk);
        chk("r1_ack1_after", wb1_ack, 0);

        // Partial write over a known word, then readback.
        do_txn(0, 1'b1, 10'h020, 32'hA1B2C3D4, 4'hF, 5, r);
        do_txn(0, 1'b1, 10'h020, 32'h11223344, 4'b0101, 5, r);
        chk("pw_mem20", mem[10'h020], 32'h44);
        chk("pw_mem21", mem[10'h021], 32'hC3);
        chk("pw_mem22", mem[10'h022], 32'h22);
        chk("pw_mem23", mem[10'h023], 32'hA1);
        do_txn(1, 1'b0, 10'h022, 32'h0, 4'h0, 6, r);   // low address bits ignored
        chk("pw_readback", r, 32'hA122C344);

        // sel = 0 write: full sequence and ack, but no write strobes.
        wen_before = wen_cnt;
        do_txn(1, 1'b1, 10'h020, 32'hFFFFFFFF, 4'h0, 5, r);
        chk("sel0_wen_pulses", wen_cnt - wen_before, 0);
        do_txn(0, 1'b0, 10'h020, 32'h0, 4'h0, 6, r);
        chk("sel0_readback", r, 32'hA122C344);

        // Reset in the XFER cycle with cnt = 2.
        do_txn(0, 1'b1, 10'h030, 32'h55555555, 4'hF, 5, r);
        drive(0, 1'b1, 10'h030, 32'h99887766, 4'hF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mr_wen",   sram_wen,   1);
            chk("mr_waddr", sram_waddr, 32'h30 + k);
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mr");
        repeat (2) begin
            @(negedge clk);
            chk("mr_ack0_in_rst", wb0_ack, 0);
        end
        chk("mr_mem30", mem[10'h030], 32'h66);
        chk("mr_mem31", mem[10'h031], 32'h77);
        chk("mr_mem32", mem[10'h032], 32'h55);
        chk("mr_mem33", mem[10'h033], 32'h55);
        rst_n = 1'b1;
        wait_ack(0, cyc);
        chk("mr_rerun_latency", cyc, 5);
        wb0_stb = 1'b0;
        @(negedge clk);
        chk("mr_word_after", {mem[10'h033], mem[10'h032], mem[10'h031], mem[10'h030]},
            32'h99887766);

        // Contention from reset: back-to-back reads, grants alternate starting with port 0.
        rst_n = 1'b0;
        drive(0, 1'b0, 10'h010, 32'h0, 4'h0);
        drive(1, 1'b0, 10'h020, 32'h0, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        n_ack = 0;
        cyc   = 0;
        while (n_ack < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            chk("ct_both_ack", wb0_ack & wb1_ack, 0);
            if (wb0_ack || wb1_ack) begin
                chk("ct_port",  wb1_ack, n_ack % 2);
                chk("ct_cycle", cyc, 6 + 7 * n_ack);
                chk("ct_rdt", wb1_ack ? wb1_rdt : wb0_rdt,
                    wb1_ack ? 32'hA122C344 : 32'hDEADBEEF);
                n_ack++;
                if (n_ack == 4) begin
                    wb0_stb = 1'b0;
                    wb1_stb = 1'b0;
                end
            end
        end
        chk("ct_acks", n_ack, 4);
        wb0_stb = 1'b0;
        wb1_stb = 1'b0;
        @(negedge clk);

        // Single requester streaming writes.
        n_ack = 0;
        cyc   = 0;
        drive(0, 1'b1, 10'h040, 32'h01010101, 4'hF);
        while (n_ack < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            chk("st_ack1", wb1_ack, 0);
            if (wb0_ack) begin
                chk("st_cycle", cyc, 5 + 6 * n_ack);
                n_ack++;
                if (n_ack == 4) wb0_stb = 1'b0;
                else            wb0_dat = 32'h01010101 * (n_ack + 1);
            end
        end
        chk("st_acks", n_ack, 4);
        wb0_stb = 1'b0;
        @(negedge clk);
        chk("st_word", {mem[10'h043], mem[10'h042], mem[10'h041], mem[10'h040]},
            32'h04040404);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/subservient_sram_arb.md
# subservient_sram_arb

Two-port arbiter and width adapter in front of the byte-wide subservient SRAM. Two 32-bit Wishbone-style requesters share the memory: the CPU on port 0 and the debug/loader master on port 1. Each granted word access becomes four byte cycles on the SRAM's 8-bit interface, which has separate read/write addresses and one-cycle registered read latency. Contention is resolved round-robin, so either requester can hold off the other for at most one transaction.

## Interface
- `aw`, default 10: SRAM byte-address width. Must be ≥ 3.
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_wb0_adr`  in  aw  port 0 byte address. Bits [1:0] are ignored (word-aligned).
- `i_wb0_dat`  in  32  port 0 write data. Byte k is bits [8k+7:8k].
- `i_wb0_sel`  in  4  port 0 write byte enables.
- `i_wb0_we`  in  1  port 0: 1 = write, 0 = read.
- `i_wb0_stb`  in  1  port 0 request. Held high until ack.
- `o_wb0_rdt`  out  32  read data, valid while `o_wb0_ack` is high.
- `o_wb0_ack`  out  1  port 0 one-cycle completion pulse.
- `i_wb1_adr`, `i_wb1_dat`, `i_wb1_sel`, `i_wb1_we`, `i_wb1_stb`, `o_wb1_rdt`, `o_wb1_ack`: port 1, identical to port 0.
- `o_sram_waddr`  out  aw  SRAM write byte address.
- `o_sram_wdata`  out  8  SRAM write data.
- `o_sram_wen`  out  1  SRAM write enable.
- `o_sram_raddr`  out  aw  SRAM read byte address.
- `o_sram_ren`  out  1  SRAM read enable.
- `i_sram_rdata`  in  8  SRAM read data, valid the cycle after the read address is presented.

## Operation
- FSM states: IDLE, XFER, DRAIN, ACK.
- Registered state:
  - `gnt`: granted port.
  - `last`: last granted port, for round-robin.
  - `cnt[1:0]`: byte index.
  - latched `adr`, `dat`, `sel`, `we`.
  - `rdt[31:0]`: assembled read word.
- IDLE, arbitration:
  - Neither stb: stay in IDLE.
  - Exactly one stb: grant that port.
  - Both stb: grant `!last`.
  - On grant: latch adr/dat/sel/we of the winner, set `gnt` and `last`, `cnt`←0, go to XFER.
- XFER, one byte per cycle, `cnt` 0→3:
  - Both SRAM addresses = {adr[aw-1:2], cnt}.
  - Write: `o_sram_wen` = sel[cnt], `o_sram_wdata` = dat[8·cnt+7:8·cnt], `o_sram_ren` = 0.
  - Read: `o_sram_ren` = 1, `o_sram_wen` = 0.
  - At cnt = 3: a write goes to ACK; a read goes to DRAIN.
- Read capture: during read XFER cycles with cnt ≥ 1 and in DRAIN, capture `i_sram_rdata` into `rdt` byte (cnt−1); in DRAIN this is byte 3. DRAIN issues no SRAM request.
- ACK:
  - Assert ack on port `gnt` only.
  - Both `o_wbN_rdt` ports always drive `rdt`. For writes, `rdt` keeps its previous value.
  - Both stb are ignored in this cycle. Next state is IDLE.
- Reads ignore `sel` and always read 4 bytes.
- A write with sel = 0 still takes the full sequence and is acked; no `wen` pulses occur.
- Outside XFER: `o_sram_wen` = `o_sram_ren` = 0. Addresses hold their last value (don't-care).
- Reset values (async, while `i_rst_n` = 0):
  - State IDLE, `cnt` = 0, `gnt` = 0, `last` = 1 (port 0 wins the first contention).
  - `rdt` = 0, both acks 0, `wen` = `ren` = 0, addresses 0, `o_sram_wdata` = 0.
- Reset mid-transaction: abort immediately and give no ack. Bytes already written stay written. After release, the requester's still-high stb is re-arbitrated normally.
- A requester dropping stb mid-transaction is not supported; the transaction completes and acks anyway.

## Timing
- Grant decided in IDLE cycle T.
- XFER in T+1..T+4, byte k in cycle T+1+k.
- Write: ack in cycle T+5. Earliest next grant (IDLE) in T+6.
- Read: byte k of SRAM data is valid in T+2+k, DRAIN in T+5, ack in T+6 with the full word in `rdt`. Earliest next grant in T+7.
- Ack is registered, high exactly one cycle per transaction, and never on both ports in the same cycle.
- No combinational path from any stb to any SRAM output.

## Test plan
- Port 0 write: adr = 0x10, dat = 0xDEADBEEF, sel = 0xF.
  - Required: `wen` in T+1..T+4 at addresses 0x10..0x13 with data EF, BE, AD, DE; `o_wb0_ack` in T+5 only.
- Port 1 read of the same word:
  - Required: `ren` in T+1..T+4; `o_wb1_ack` in T+6 with `o_wb1_rdt` = 0xDEADBEEF; `o_wb0_ack` stays 0.
- Partial write: sel = 0b0101, dat = 0x11223344 to 0x20, then read 0x20 back.
  - Required: only bytes 0x20 = 44 and 0x22 = 22 are written; readback shows bytes 1 and 3 unchanged.
- Contention: both stb held high after reset with back-to-back reads.
  - Required: grants alternate 0, 1, 0, 1, starting with port 0; each transaction is 7 cycles apart.
- Reset mid-write: assert `i_rst_n` low in the XFER cycle with cnt = 2.
  - Required: all outputs take reset values immediately; no ack; bytes 0–1 are written and bytes 2–3 are not. After release with stb still high, the full write re-runs and is acked.
- Single requester streaming writes, port 0 only.
  - Required: an ack every 6 cycles; port 1 ack never asserts.
